// File: rtl/imm_gen_stage_pkg.sv
// Shared types and opcode constants for the immediate-generation stage.
package imm_gen_stage_pkg;

    // Immediate format tag carried with every decoded instruction
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_t;

    // RV32I/RV64I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_ALU_I   = 7'b0010011;
    localparam logic [6:0] OP_ALU_I32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    // Entries are sized for the widest legal XLEN; narrower builds use the low bits
    localparam int unsigned XLEN_MAX = 64;

    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        imm_fmt_t            fmt;
    } imm_entry_t;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder: extracts and sign-extends the immediate
// of every RV32I/RV64I format plus the CSR zimm field.
module imm_gen_stage_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_t        fmt_o
);

    logic [31:0] w_raw;
    imm_fmt_t    w_fmt;

    // Build a 32-bit immediate whose bit 31 is the sign (zimm has bit 31 clear)
    always_comb begin
        w_raw = '0;
        w_fmt = FMT_NONE;
        case (instr_i[6:0])
            OP_LUI, OP_AUIPC: begin
                w_fmt = FMT_U;
                w_raw = {instr_i[31:12], 12'b0};
            end
            OP_ALU_I, OP_LOAD, OP_JALR: begin
                w_fmt = FMT_I;
                w_raw = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_ALU_I32: begin
                if (XLEN == 64) begin
                    w_fmt = FMT_I;
                    w_raw = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OP_STORE: begin
                w_fmt = FMT_S;
                w_raw = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                w_fmt = FMT_B;
                w_raw = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OP_JAL: begin
                w_fmt = FMT_J;
                w_raw = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            end
            OP_SYSTEM: begin
                if (instr_i[14]) begin
                    w_fmt = FMT_Z;
                    w_raw = {27'b0, instr_i[19:15]};
                end
            end
            default: begin
                w_fmt = FMT_NONE;
                w_raw = '0;
            end
        endcase
    end

    assign imm_o = XLEN'($signed(w_raw));
    assign fmt_o = w_fmt;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage between decode and issue.
// Decodes on the input side, then buffers {instr, pc, imm, fmt} behind a
// valid/ready handshake with either a two-entry skid buffer or a single register.
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_t        fmt_o
);

    logic [XLEN-1:0] w_dec_imm;
    imm_fmt_t        w_dec_fmt;
    imm_entry_t      w_in_entry;
    imm_entry_t      w_head;
    logic            w_valid;
    logic            w_ready;

    imm_gen_stage_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i (instr_i),
        .imm_o   (w_dec_imm),
        .fmt_o   (w_dec_fmt)
    );

    // Pack the incoming instruction into a full-width entry
    always_comb begin
        w_in_entry       = '0;
        w_in_entry.instr = instr_i;
        w_in_entry.pc    = XLEN_MAX'(pc_i);
        w_in_entry.imm   = XLEN_MAX'(w_dec_imm);
        w_in_entry.fmt   = w_dec_fmt;
    end

    if (SKID_EN) begin : g_skid
        occ_t       r_occ;
        imm_entry_t r_main;
        imm_entry_t r_skid;
        logic       r_ready;
        logic       w_in_xfer;
        logic       w_out_xfer;

        assign w_in_xfer  = valid_i & r_ready;
        assign w_out_xfer = (r_occ != OCC_EMPTY) & ready_i;

        // Occupancy FSM: main is always the oldest entry, skid holds the second;
        // ready is registered from the next occupancy so no comb path crosses.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_occ   <= OCC_EMPTY;
                r_ready <= 1'b1;
                r_main  <= '0;
            end else if (flush_i) begin
                r_occ   <= OCC_EMPTY;
                r_ready <= 1'b1;
            end else begin
                case (r_occ)
                    OCC_EMPTY: begin
                        if (w_in_xfer) begin
                            r_main <= w_in_entry;
                            r_occ  <= OCC_ONE;
                        end
                    end
                    OCC_ONE: begin
                        if (w_in_xfer && w_out_xfer) begin
                            r_main <= w_in_entry;
                        end else if (w_in_xfer) begin
                            r_skid  <= w_in_entry;
                            r_occ   <= OCC_FULL;
                            r_ready <= 1'b0;
                        end else if (w_out_xfer) begin
                            r_occ <= OCC_EMPTY;
                        end
                    end
                    OCC_FULL: begin
                        if (w_out_xfer) begin
                            r_main  <= r_skid;
                            r_occ   <= OCC_ONE;
                            r_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_occ   <= OCC_EMPTY;
                        r_ready <= 1'b1;
                    end
                endcase
            end
        end

        assign w_head  = r_main;
        assign w_valid = (r_occ != OCC_EMPTY);
        assign w_ready = r_ready;
    end else begin : g_single
        imm_entry_t r_main;
        logic       r_valid;
        logic       w_in_xfer;

        assign w_ready   = ready_i | ~r_valid;
        assign w_in_xfer = valid_i & w_ready;

        // Single pipeline register: refill when empty or when the entry leaves
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_valid <= 1'b0;
                r_main  <= '0;
            end else if (flush_i) begin
                r_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_main  <= w_in_entry;
                r_valid <= 1'b1;
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end
        end

        assign w_head  = r_main;
        assign w_valid = r_valid;
    end

    assign valid_o = w_valid;
    assign ready_o = w_ready;
    assign instr_o = w_head.instr;
    assign pc_o    = w_head.pc[XLEN-1:0];
    assign imm_o   = w_head.imm[XLEN-1:0];
    assign fmt_o   = w_head.fmt;

    // Upper entry bits are always zero on narrow builds and never reach a port
    if (XLEN < XLEN_MAX) begin : g_narrow
        logic w_unused_hi;
        assign w_unused_hi = ^{w_head.pc[XLEN_MAX-1:XLEN], w_head.imm[XLEN_MAX-1:XLEN]};
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;
    import imm_gen_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, valid, rdy;
    logic [31:0] instr;
    logic [63:0] pc;

    logic        a_ready, a_valid;
    logic [31:0] a_instr, a_pc, a_imm;
    imm_fmt_t    a_fmt;
    logic        b_ready, b_valid;
    logic [31:0] b_instr;
    logic [63:0] b_pc, b_imm;
    imm_fmt_t    b_fmt;

    // XLEN=32 with skid buffer
    imm_gen_stage #(.XLEN(32), .SKID_EN(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(a_ready),
        .instr_i(instr), .pc_i(pc[31:0]), .valid_o(a_valid), .ready_i(rdy),
        .instr_o(a_instr), .pc_o(a_pc), .imm_o(a_imm), .fmt_o(a_fmt));

    // XLEN=64 with single register
    imm_gen_stage #(.XLEN(64), .SKID_EN(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(b_ready),
        .instr_i(instr), .pc_i(pc), .valid_o(b_valid), .ready_i(rdy),
        .instr_o(b_instr), .pc_o(b_pc), .imm_o(b_imm), .fmt_o(b_fmt));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference immediate from the ISA field layout, using 64-bit signed arithmetic
    function automatic logic [63:0] ref_imm(input logic [31:0] w, input bit x64,
                                            output imm_fmt_t f);
        longint s;
        longint r;
        s = longint'($signed(w));
        r = 0;
        f = FMT_NONE;
        case (w[6:0])
            7'h37, 7'h17: begin f = FMT_U; r = s & ~longint'(64'hFFF); end
            7'h13, 7'h03, 7'h67: begin f = FMT_I; r = s >>> 20; end
            7'h1B: if (x64) begin f = FMT_I; r = s >>> 20; end
            7'h23: begin f = FMT_S; r = ((s >>> 25) <<< 5) | longint'(w[11:7]); end
            7'h63: begin
                f = FMT_B;
                r = ((s >>> 31) <<< 12) | (longint'(w[7]) << 11)
                  | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
            end
            7'h6F: begin
                f = FMT_J;
                r = ((s >>> 31) <<< 20) | (longint'(w[19:12]) << 12)
                  | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
            end
            7'h73: if (w[14]) begin f = FMT_Z; r = longint'(w[19:15]); end
            default: r = 0;
        endcase
        if (!x64) r = r & longint'(64'hFFFF_FFFF);
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h13, 7'h03, 7'h67,
                                 7'h23, 7'h63, 7'h6F, 7'h73, 7'h1B};
        logic [31:0] w;
        int unsigned k;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 10) w[6:0] = ops[k];
        return w;
    endfunction

    // Behavioural model: each stage is a FIFO of bounded depth
    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        imm_fmt_t    fmt;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    bit   a_zero = 1'b0, b_zero = 1'b0, model_live = 1'b0;

    always @(posedge clk) begin
        ent_t e;
        imm_fmt_t f;
        int pre;
        bit in_x, out_x;
        if (rst) begin
            qa.delete(); qb.delete();
            a_zero = 1'b1; b_zero = 1'b1; model_live = 1'b1;
        end else if (model_live) begin
            if (flush) begin
                qa.delete(); qb.delete();
            end else begin
                pre   = qa.size();
                out_x = (pre > 0) && rdy;
                in_x  = valid && (pre < 2);
                if (out_x) void'(qa.pop_front());
                if (in_x) begin
                    e.instr = instr; e.pc = pc;
                    e.imm = ref_imm(instr, 1'b0, f); e.fmt = f;
                    qa.push_back(e); a_zero = 1'b0;
                end
                pre   = qb.size();
                out_x = (pre > 0) && rdy;
                in_x  = valid && ((pre == 0) || rdy);
                if (out_x) void'(qb.pop_front());
                if (in_x) begin
                    e.instr = instr; e.pc = pc;
                    e.imm = ref_imm(instr, 1'b1, f); e.fmt = f;
                    qb.push_back(e); b_zero = 1'b0;
                end
            end
        end
    end

    // Compare DUT outputs with the model every cycle
    always @(negedge clk) begin
        if (model_live) begin
            chk("a_valid", a_valid, qa.size() > 0);
            chk("a_ready", a_ready, qa.size() < 2);
            if (qa.size() > 0) begin
                chk("a_instr", a_instr, qa[0].instr);
                chk("a_pc", a_pc, qa[0].pc[31:0]);
                chk("a_imm", a_imm, qa[0].imm[31:0]);
                chk("a_fmt", a_fmt, qa[0].fmt);
            end else if (a_zero) begin
                chk("a_rst_data", {a_instr, a_imm}, '0);
                chk("a_rst_fmt", a_fmt, FMT_NONE);
            end
            chk("b_valid", b_valid, qb.size() > 0);
            chk("b_ready", b_ready, (qb.size() == 0) || rdy);
            if (qb.size() > 0) begin
                chk("b_instr", b_instr, qb[0].instr);
                chk("b_pc", b_pc, qb[0].pc);
                chk("b_imm", b_imm, qb[0].imm);
                chk("b_fmt", b_fmt, qb[0].fmt);
            end else if (b_zero) begin
                chk("b_rst_data", b_imm | b_pc, '0);
                chk("b_rst_fmt", b_fmt, FMT_NONE);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] words [8] = '{32'h12345037, 32'hFFF00093, 32'h00502623, 32'h00000463,
                               32'hFFDFF06F, 32'h3002D073, 32'h80000037, 32'h0000007F};
    logic [31:0] exp32 [8] = '{32'h12345000, 32'hFFFFFFFF, 32'h0000000C, 32'h00000008,
                               32'hFFFFFFFC, 32'h00000005, 32'h80000000, 32'h00000000};
    logic [63:0] exp64 [8] = '{64'h12345000, '1, 64'hC, 64'h8, 64'hFFFFFFFFFFFFFFFC,
                               64'h5, 64'hFFFFFFFF80000000, 64'h0};
    imm_fmt_t    expf  [8] = '{FMT_U, FMT_I, FMT_S, FMT_B, FMT_J, FMT_Z, FMT_U, FMT_NONE};

    initial begin
        imm_fmt_t f;
        logic [63:0] pcv;
        logic [31:0] seen [$];
        bit acc;

        rst = 1'b1; flush = 1'b0; valid = 1'b0; rdy = 1'b0; instr = '0; pc = '0;

        // Pin the reference decoder to hand-computed values
        for (int i = 0; i < 8; i++) begin
            chk("pin_imm64", ref_imm(words[i], 1'b1, f), exp64[i]);
            chk("pin_fmt", f, expf[i]);
            chk("pin_imm32", ref_imm(words[i], 1'b0, f), {32'h0, exp32[i]});
        end

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_a_imm", a_imm, 0);
        chk("rst_a_pc", a_pc, 0);
        chk("rst_a_fmt", a_fmt, FMT_NONE);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_b_ready", b_ready, 1);

        // Back-to-back stream, one result per cycle after one cycle of latency
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1; instr = words[i]; pc = 64'h1000 + 64'(4 * i);
            tick();
            chk("stream_a_imm", a_imm, exp32[i]);
            chk("stream_a_fmt", a_fmt, expf[i]);
            chk("stream_b_imm", b_imm, exp64[i]);
            chk("stream_a_pc", a_pc, 32'h1000 + 32'(4 * i));
        end
        valid = 1'b0;
        repeat (3) tick();

        // Stall with valid held high: skid buffer fills, then drains in order
        rdy = 1'b0; valid = 1'b1; instr = 32'h00100093; pcv = 64'h100; pc = pcv;
        for (int k = 0; k < 6; k++) begin
            acc = (qa.size() < 2);
            tick();
            if (acc && pcv != 64'h108) pcv += 4;
            pc = pcv;
        end
        chk("stall_a_ready", a_ready, 0);
        chk("stall_a_valid", a_valid, 1);
        chk("stall_a_pc", a_pc, 32'h100);
        chk("stall_a_imm", a_imm, 32'h1);
        rdy = 1'b1;
        seen.push_back(a_pc);
        for (int k = 0; k < 6; k++) begin
            acc = valid && (qa.size() < 2);
            tick();
            if (acc) begin
                if (pcv == 64'h108) valid = 1'b0;
                else pcv += 4;
                pc = pcv;
            end
            if (a_valid) seen.push_back(a_pc);
        end
        chk("drain_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("drain_0", seen[0], 32'h100);
            chk("drain_1", seen[1], 32'h104);
            chk("drain_2", seen[2], 32'h108);
        end

        // Flush while full; the input of the flush cycle must vanish
        rdy = 1'b0; valid = 1'b1; instr = 32'h00200093; pc = 64'h200;
        tick();
        pc = 64'h204;
        tick();
        flush = 1'b1; instr = 32'h7FF00093; pc = 64'hBAD0;
        tick();
        flush = 1'b0; valid = 1'b0;
        chk("flush_a_valid", a_valid, 0);
        chk("flush_a_ready", a_ready, 1);
        chk("flush_b_valid", b_valid, 0);
        chk("flush_b_ready", b_ready, 1);
        valid = 1'b1; rdy = 1'b1; pc = 64'h300; instr = 32'h00000463;
        tick();
        valid = 1'b0;
        chk("post_flush_a_pc", a_pc, 32'h300);
        tick();

        // Reset while one entry is held and a transfer is offered
        rdy = 1'b0; valid = 1'b1; pc = 64'h400; instr = 32'h12345037;
        tick();
        rst = 1'b1; rdy = 1'b1; pc = 64'h404;
        tick();
        rst = 1'b0; valid = 1'b0;
        chk("mid_rst_a_valid", a_valid, 0);
        chk("mid_rst_a_imm", a_imm, 0);
        chk("mid_rst_a_fmt", a_fmt, FMT_NONE);
        chk("mid_rst_a_ready", a_ready, 1);
        chk("mid_rst_b_imm", b_imm, 0);
        chk("mid_rst_b_valid", b_valid, 0);
        tick();

        // ready_i toggling with continuous valid_i
        valid = 1'b1; instr = 32'hFFF00093; pcv = 64'h500;
        for (int k = 0; k < 8; k++) begin
            rdy = (k % 2 == 0); pc = pcv;
            tick();
            pcv += 4;
        end
        rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pc = pcv; tick(); pcv += 4;
        end
        valid = 1'b0;
        tick();

        // Randomized traffic with occasional flush and reset
        for (int k = 0; k < 3000; k++) begin
            valid = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            instr = rand_instr();
            pc    = {$urandom, $urandom};
            tick();
        end
        rst = 1'b0; flush = 1'b0; valid = 1'b0; rdy = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
